pipe_stage_buf: RTL

Parametrised inter-stage pipeline buffer for the MIPS core. It is the next generation of the fixed ID→EXE / EXE→MEM stage registers. It carries a generic data payload plus a control-bit vector between two stages with a valid/ready handshake, a small skid FIFO, flush (bubble injection) and legacy freeze support. It also has a sticky halt latch so that nothing follows a halting instruction. One instance sits between each pair of adjacent pipeline stages.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/pipe_buf_mem.sv | 48 ++++
 rtl/pipe_stage_buf.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the inter-stage pipeline buffers of the MIPS core:
//   - layout of the stage control vector (halted flag at bit 0)
//   - the bubble encoding of the control vector (all zeros)
//   - per-stage payload/control widths used when instantiating pipe_stage_buf
//   - wrap_inc: modulo-depth pointer increment (depth need not be a power of 2)
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Control vector field widths.
    localparam int PC_W       = 32;
    localparam int ALU_CTRL_W = 4;
    localparam int DEST_REG_W = 5;
    localparam int CTRL_PAD_W = 3;

    // Control vector layout, MSB first. The halted flag is the LSB so its
    // index stays fixed even if upper fields grow.
    typedef struct packed {
        logic [PC_W-1:0]       pc;           // 47:16
        logic [CTRL_PAD_W-1:0] reserved;     // 15:13
        logic [ALU_CTRL_W-1:0] alu_ctrl;     // 12:9
        logic [DEST_REG_W-1:0] dest_reg_num; // 8:4
        logic                  jump;         // 3
        logic                  mem_write;    // 2
        logic                  reg_write;    // 1
        logic                  halted;       // 0
    } stage_ctrl_t;

    localparam int CTRL_HALT_BIT = 0;

    // Per-stage widths (payload is val1 || val2).
    localparam int ID_EXE_DATA_W  = 64;
    localparam int ID_EXE_CTRL_W  = $bits(stage_ctrl_t);
    localparam int EXE_MEM_DATA_W = 64;
    localparam int EXE_MEM_CTRL_W = $bits(stage_ctrl_t);

    // An all-zero control vector is a bubble: no writes, no jump, not halted.
    localparam logic [ID_EXE_CTRL_W-1:0] BUBBLE_CTRL = '0;

    // Circular pointer increment: depth-1 wraps to 0.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// -----------------------------------------------------------------------------
// pipe_buf_mem
// DEPTH x WIDTH register array backing the skid FIFO of pipe_stage_buf.
// One synchronous write port, one combinational read mux. Storage is not reset;
// the owner masks the read data whenever the buffer is empty.
// Ports:
//   clk      clock, writes on rising edge
//   wr_en    write strobe
//   wr_addr  entry written when wr_en=1
//   wr_data  word to write
//   rd_addr  entry presented on rd_data
//   rd_data  contents of entry rd_addr
// -----------------------------------------------------------------------------
module pipe_buf_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 112,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] entry_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == PTR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // The read pointer only ever holds 0..DEPTH-1, so the mux never selects
    // a non-existent entry even when DEPTH is not a power of two.
    assign rd_data = entry_q[rd_addr];

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Inter-stage pipeline buffer: payload + control vector carried between two
// adjacent stages with a valid/ready handshake, a DEPTH-entry skid FIFO,
// flush (bubble injection), legacy freeze and a sticky halt latch.
// Parameters:
//   DATA_W    payload width
//   CTRL_W    control vector width (all zeros = bubble)
//   DEPTH     skid entries, 1..4
//   HALT_BIT  index of the halted flag inside the control vector
// Ports:
//   clk        clock, rising edge
//   rst_b      asynchronous reset, active high
//   in_valid   upstream offers an entry
//   in_ready   buffer accepts this cycle
//   in_data    offered payload
//   in_ctrl    offered control vector
//   out_valid  head entry present
//   out_ready  downstream consumes head
//   out_data   head payload (zero when empty)
//   out_ctrl   head control (bubble when empty)
//   flush      drop every entry, including a same-cycle offer
//   freeze     global stall: no push, no pop, state held, handshakes masked
//   halted     sticky, set when a halting entry is accepted
//   occupancy  number of stored entries
// -----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W   = ID_EXE_DATA_W,
    parameter int CTRL_W   = ID_EXE_CTRL_W,
    parameter int DEPTH    = 2,
    parameter int HALT_BIT = CTRL_HALT_BIT
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    input  logic                       flush,
    input  logic                       freeze,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             halted_reg, halted_next;

    logic not_empty;
    logic not_full;
    logic push;
    logic pop;

    logic [DATA_W+CTRL_W-1:0] head_word;
    logic [DATA_W-1:0]        head_data;
    logic [CTRL_W-1:0]        head_ctrl;

    assign not_empty = (count_reg != '0);
    assign not_full  = (count_reg < CNT_W'(DEPTH));

    // Ready comes from registered state only, except for a single-entry
    // buffer: there a full slot being consumed this cycle may be refilled in
    // the same cycle, otherwise DEPTH=1 would run at half rate.
    generate
        if (DEPTH == 1) begin : g_ready_single
            assign in_ready = ~halted_reg & ~freeze & (not_full | out_ready);
        end else begin : g_ready_multi
            assign in_ready = ~halted_reg & ~freeze & not_full;
        end
    endgenerate

    assign out_valid = not_empty & ~freeze;

    // in_ready and out_valid already fold in freeze; flush vetoes both moves.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        halted_next = halted_reg;

        if (flush) begin
            // halted survives a redirect: only reset may release a halt.
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = PTR_W'(wrap_inc(int'(wr_ptr_reg), DEPTH));
                if (in_ctrl[HALT_BIT]) begin
                    halted_next = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_next = PTR_W'(wrap_inc(int'(rd_ptr_reg), DEPTH));
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            halted_reg <= halted_next;
        end
    end

    pipe_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + CTRL_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data ({in_data, in_ctrl}),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_word)
    );

    assign {head_data, head_ctrl} = head_word;

    // Storage is never reset, so an empty buffer must present zeros; this
    // also makes an async reset blank the outputs immediately.
    assign out_data  = not_empty ? head_data : '0;
    assign out_ctrl  = not_empty ? head_ctrl : CTRL_W'(BUBBLE_CTRL);
    assign halted    = halted_reg;
    assign occupancy = count_reg;

endmodule
